// File: rtl/router_pkg.sv
// Shared types and helpers for the input router datapath.
package router_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } loader_state_e;

  // Number of stream elements packed into one SPAD word.
  function automatic int lanes(input int spad_w, input int data_w);
    return spad_w / data_w;
  endfunction

endpackage

// File: rtl/word_packer.sv
// Packs stream elements into a SPAD word, lane 0 in the LSBs; zero-fills
// lanes above the final element of a load.
module word_packer
  import router_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int SPAD_DATA_WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_vld,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic                       in_last,
  output logic                       word_complete,
  output logic                       vld_p1,
  output logic [SPAD_DATA_WIDTH-1:0] word_p1
);

  localparam int LANES  = lanes(SPAD_DATA_WIDTH, DATA_WIDTH);
  localparam int LANE_W = $clog2(LANES);

  logic [LANE_W-1:0]          lane_p0;
  logic [SPAD_DATA_WIDTH-1:0] pack_p0;
  logic [SPAD_DATA_WIDTH-1:0] merged;

  // Lanes below the current index keep packed data, the current lane takes
  // the new element, every lane above is forced to zero.
  function automatic logic [SPAD_DATA_WIDTH-1:0] merge_lane(
    input logic [SPAD_DATA_WIDTH-1:0] pack,
    input logic [LANE_W-1:0]          lane,
    input logic [DATA_WIDTH-1:0]      data
  );
    logic [SPAD_DATA_WIDTH-1:0] w;
    w = '0;
    for (int k = 0; k < LANES; k++) begin
      if (k < int'(lane))
        w[k*DATA_WIDTH +: DATA_WIDTH] = pack[k*DATA_WIDTH +: DATA_WIDTH];
      else if (k == int'(lane))
        w[k*DATA_WIDTH +: DATA_WIDTH] = data;
    end
    return w;
  endfunction

  // Word is ready when the top lane fills or the final element arrives.
  always_comb begin
    merged        = merge_lane(pack_p0, lane_p0, in_data);
    word_complete = in_vld & ((lane_p0 == LANE_W'(LANES - 1)) | in_last);
  end

  // p0 -> p1: accumulate lanes; hand a finished word to the write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_p0 <= '0;
      pack_p0 <= '0;
      vld_p1  <= 1'b0;
      word_p1 <= '0;
    end else begin
      vld_p1 <= word_complete;
      if (word_complete)
        word_p1 <= merged;
      if (in_vld) begin
        if (word_complete) begin
          lane_p0 <= '0;
          pack_p0 <= '0;
        end else begin
          lane_p0 <= lane_p0 + LANE_W'(1);
          pack_p0 <= merged;
        end
      end
    end
  end

endmodule

// File: rtl/input_spad_loader.sv
// Streams activation elements into the input SPAD, LANES per word, at
// consecutive addresses from a programmed base, then pulses done.
module input_spad_loader
  import router_pkg::*;
#(
  parameter int SPAD_DEPTH      = 256,
  parameter int SPAD_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH      = 8,
  parameter int DATA_WIDTH      = 8,
  parameter int COUNT_WIDTH     = 12
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_reg_clear,
  input  logic                       i_start,
  input  logic [ADDR_WIDTH-1:0]      i_base_addr,
  input  logic [COUNT_WIDTH-1:0]     i_elem_count,
  input  logic [DATA_WIDTH-1:0]      i_data,
  input  logic                       i_valid,
  output logic                       o_ready,
  output logic                       o_spad_write_en,
  output logic [ADDR_WIDTH-1:0]      o_spad_write_addr,
  output logic [SPAD_DATA_WIDTH-1:0] o_spad_data,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_error
);

  localparam int LANES      = lanes(SPAD_DATA_WIDTH, DATA_WIDTH);
  localparam int LANE_SHIFT = $clog2(LANES);
  localparam int WORDS_W    = COUNT_WIDTH + 1;

  loader_state_e          state_q, state_d;
  logic [COUNT_WIDTH-1:0] count_q, elem_cnt_q;
  logic [ADDR_WIDTH-1:0]  base_q, word_idx_q, addr_p1;
  logic                   ready_q, busy_q, done_q, error_q;
  logic [WORDS_W-1:0]     words;
  logic                   clr, overflow, xfer, last, error_d, word_done;

  assign clr = i_rst | i_reg_clear;

  // Request decode and handshake qualifiers.
  always_comb begin
    words    = (WORDS_W'(i_elem_count) + WORDS_W'(LANES - 1)) >> LANE_SHIFT;
    overflow = words > WORDS_W'(SPAD_DEPTH);
    xfer     = i_valid & ready_q;
    last     = elem_cnt_q == (count_q - COUNT_WIDTH'(1));
  end

  // Next-state logic; a rejected start raises error and stays in IDLE.
  always_comb begin
    state_d = state_q;
    error_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          if (i_elem_count == '0)
            state_d = DONE;
          else if (overflow)
            error_d = 1'b1;
          else
            state_d = LOAD;
        end
      end
      LOAD:    if (xfer && last) state_d = FLUSH;
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  word_packer #(
    .DATA_WIDTH     (DATA_WIDTH),
    .SPAD_DATA_WIDTH(SPAD_DATA_WIDTH)
  ) u_packer (
    .clk          (i_clk),
    .rst          (clr),
    .in_vld       (xfer),
    .in_data      (i_data),
    .in_last      (last),
    .word_complete(word_done),
    .vld_p1       (o_spad_write_en),
    .word_p1      (o_spad_data)
  );

  // p0 -> p1: state, counters, address generation and registered flags.
  always_ff @(posedge i_clk) begin
    if (clr) begin
      state_q    <= IDLE;
      count_q    <= '0;
      base_q     <= '0;
      elem_cnt_q <= '0;
      word_idx_q <= '0;
      addr_p1    <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= state_d == LOAD;
      busy_q  <= state_d != IDLE;
      done_q  <= state_d == DONE;
      error_q <= error_d;
      if (state_q == IDLE && i_start) begin
        count_q    <= i_elem_count;
        base_q     <= i_base_addr;
        elem_cnt_q <= '0;
        word_idx_q <= '0;
      end
      if (xfer) begin
        elem_cnt_q <= elem_cnt_q + COUNT_WIDTH'(1);
        if (word_done) begin
          addr_p1 <= base_q + word_idx_q;
          if (!last)
            word_idx_q <= word_idx_q + ADDR_WIDTH'(1);
        end
      end
    end
  end

  assign o_ready           = ready_q;
  assign o_busy            = busy_q;
  assign o_done            = done_q;
  assign o_error           = error_q;
  assign o_spad_write_addr = addr_p1;

endmodule
